// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester, round-robin arbiter in front of a single-port data memory.
// Each access is a three-cycle transaction: IDLE (arbitrate and latch the
// winner's request) -> ACCESS (grant pulse plus one memory strobe) ->
// RESP (completion pulse, read data on the winner's rdata bus).
//
// Parameters
//   ADDR_W     byte-address width of the requester and memory address ports
//   DATA_W     data width
//
// Ports
//   clk              single clock, rising edge
//   rst              asynchronous, active-high reset
//   m0_req/m1_req    access request; held stable with we/addr/wdata until gnt
//   m0_we/m1_we      1 = write, 0 = read
//   m0_addr/m1_addr  byte address, forwarded unchanged (including bits [1:0])
//   m0_wdata/m1_wdata write data
//   m0_gnt/m1_gnt    one-cycle grant pulse, high during ACCESS
//   m0_rvalid/m1_rvalid one-cycle completion pulse, high during RESP
//   m0_rdata/m1_rdata read data while rvalid is high, zero otherwise
//   mem_read/mem_write memory strobes, at most one high, only during ACCESS
//   mem_addr/mem_wdata registered memory address and write data
//   mem_rdata        memory read data, captured at the end of ACCESS
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Transaction phases. The unused encoding falls back to IDLE.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    // Requester identifiers used for the winner and the priority pointer.
    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0]        r_state;
    logic              r_ptr;        // preferred requester when both request
    logic              r_win;        // requester owning the current transaction
    logic              r_we;         // latched direction of the current transaction
    logic [ADDR_W-1:0] r_addr;       // drives mem_addr
    logic [DATA_W-1:0] r_wdata;      // drives mem_wdata
    logic              r_m0_gnt;
    logic              r_m1_gnt;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_m0_rvalid;
    logic              r_m1_rvalid;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic              w_any_req;
    logic              w_start;      // arbitration happens at this edge
    logic              w_sel;        // winner of this arbitration
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [1:0]        w_next_state;
    logic              w_in_access;
    logic              w_in_resp;
    logic [DATA_W-1:0] w_resp_data;  // value handed to the winner during RESP

    assign w_any_req   = m0_req | m1_req;
    assign w_start     = (r_state == ST_IDLE) & w_any_req;
    assign w_in_access = (r_state == ST_ACCESS);
    assign w_in_resp   = (r_state == ST_RESP);

    // Next-state decode for the IDLE -> ACCESS -> RESP -> IDLE cycle.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Round-robin winner: a lone requester always wins, the pointer only
    // breaks ties.
    always_comb begin
        w_sel = REQ_M0;
        if (m0_req && m1_req) begin
            w_sel = r_ptr;
        end else if (m1_req) begin
            w_sel = REQ_M1;
        end else begin
            w_sel = REQ_M0;
        end
    end

    // Request fields of the selected requester.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = ADDR_ZERO;
        w_sel_wdata = DATA_ZERO;
        if (w_sel == REQ_M1) begin
            w_sel_we    = m1_we;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
        end else begin
            w_sel_we    = m0_we;
            w_sel_addr  = m0_addr;
            w_sel_wdata = m0_wdata;
        end
    end

    // Response payload: memory data for reads, zero for writes.
    always_comb begin
        w_resp_data = DATA_ZERO;
        if (r_we) begin
            w_resp_data = DATA_ZERO;
        end else begin
            w_resp_data = mem_rdata;
        end
    end

    // -----------------------------------------------------------------------
    // Sequential logic
    // -----------------------------------------------------------------------

    // Transaction state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Priority pointer: after serving a requester, prefer the other one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= REQ_M0;
        end else if (w_in_resp) begin
            r_ptr <= ~r_win;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Latch the winning request; these registers feed the memory directly so
    // address and write data cannot move during ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win   <= REQ_M0;
            r_we    <= 1'b0;
            r_addr  <= ADDR_ZERO;
            r_wdata <= DATA_ZERO;
        end else if (w_start) begin
            r_win   <= w_sel;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end else begin
            r_win   <= r_win;
            r_we    <= r_we;
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
        end
    end

    // Grant and memory strobes: set at the arbitration edge, so they are high
    // for exactly the ACCESS cycle; reset clears them without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0_gnt    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (w_start) begin
            r_m0_gnt    <= (w_sel == REQ_M0);
            r_m1_gnt    <= (w_sel == REQ_M1);
            r_mem_read  <= ~w_sel_we;
            r_mem_write <= w_sel_we;
        end else begin
            r_m0_gnt    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    // Completion pulse and read data for RESP; the loser's bus and both buses
    // outside RESP are held at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= DATA_ZERO;
            r_m1_rdata  <= DATA_ZERO;
        end else if (w_in_access) begin
            r_m0_rvalid <= (r_win == REQ_M0);
            r_m1_rvalid <= (r_win == REQ_M1);
            r_m0_rdata  <= (r_win == REQ_M0) ? w_resp_data : DATA_ZERO;
            r_m1_rdata  <= (r_win == REQ_M1) ? w_resp_data : DATA_ZERO;
        end else begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= DATA_ZERO;
            r_m1_rdata  <= DATA_ZERO;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -----------------------------------------------------------------------
    assign m0_gnt    = r_m0_gnt;
    assign m1_gnt    = r_m1_gnt;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the byte-address width of the memory and requester address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 m0_req, m1_req  input  1  SHALL request one memory access from requester 0 / 1.
REQ-006 m0_we, m1_we  input  1  SHALL select write (1) or read (0).
REQ-007 m0_addr, m1_addr  input  ADDR_W  SHALL be the byte address of the access.
REQ-008 m0_wdata, m1_wdata  input  DATA_W  SHALL be the write data.
REQ-009 m0_gnt, m1_gnt  output  1  SHALL be a one-cycle grant pulse to the winning requester.
REQ-010 m0_rvalid, m1_rvalid  output  1  SHALL be a one-cycle completion pulse to the granted requester.
REQ-011 m0_rdata, m1_rdata  output  DATA_W  SHALL carry read data while the matching rvalid is high.
REQ-012 mem_read, mem_write  output  1  SHALL drive the data memory read and write strobes.
REQ-013 mem_addr  output  ADDR_W  SHALL drive the data memory byte address.
REQ-014 mem_wdata  output  DATA_W  SHALL drive the data memory write data.
REQ-015 mem_rdata  input  DATA_W  SHALL receive the data memory read data.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RESP. IDLE->ACCESS SHALL occur when any req is high. ACCESS->RESP and RESP->IDLE SHALL occur unconditionally.
REQ-017 In IDLE with a req high, the block SHALL select a winner, latch that requester's we, addr and wdata, and enter ACCESS.
REQ-018 Arbitration SHALL be round-robin:
- a priority pointer selects the preferred requester when both reqs are high;
- if only one req is high, that requester SHALL win regardless of the pointer;
- on leaving RESP, the pointer SHALL point to the requester that was not just served.
REQ-019 The winner's gnt SHALL be high for exactly the ACCESS cycle; the loser's gnt SHALL stay low.
REQ-020 Requesters SHALL hold req, we, addr and wdata stable until gnt. If req is still high when the FSM returns to IDLE, it SHALL be treated as a new request.
REQ-021 In ACCESS, exactly one of mem_read or mem_write SHALL be high, according to the latched we.
REQ-022 mem_addr and mem_wdata SHALL come from registers and SHALL be stable for all of ACCESS.
REQ-023 mem_read and mem_write SHALL never be high together, and SHALL both be low in IDLE and RESP.
REQ-024 For a read, mem_rdata SHALL be captured at the end of ACCESS and presented on the winner's rdata during RESP.
REQ-025 For a write, rdata SHALL be 0 during RESP.
REQ-026 The winner's rvalid SHALL be high for exactly the RESP cycle. Both rdata buses SHALL be 0 whenever their rvalid is low.
REQ-027 Latency SHALL be as follows: req sampled at edge k -> gnt during cycle k+1 -> rvalid during cycle k+2. Peak throughput SHALL be one access per 3 cycles.
REQ-028 addr[1:0] SHALL be passed through unchanged. Word selection is the memory's responsibility.
REQ-029 A req that arrives during ACCESS or RESP SHALL be ignored until the FSM is back in IDLE.

Reset
REQ-030 While rst is high, the block SHALL immediately force:
- state = IDLE;
- pointer = requester 0;
- all gnt, rvalid, mem_read, mem_write = 0;
- mem_addr, mem_wdata, m0_rdata, m1_rdata = 0.
REQ-031 Asserting rst during ACCESS SHALL drop the strobe asynchronously and discard the transaction; no rvalid SHALL be issued for it.
REQ-032 The first arbitration after rst deasserts SHALL be evaluated at the first rising clk edge with rst low.

Verification
REQ-033 Write then read: m0 writes 0xDEADBEEF to addr 0x010, then reads 0x010 -> one mem_write cycle with mem_addr=0x010, then m0_rvalid with m0_rdata=0xDEADBEEF.
REQ-034 Simultaneous requests after reset: m0 and m1 both read -> m0_gnt first, m1_gnt 3 cycles later, no cycle with both gnts high.
REQ-035 Continuous contention: both reqs held high for 12 cycles -> grant order m0, m1, m0, m1, each rvalid 1 cycle after its gnt.
REQ-036 Single requester: only m1 requests, repeatedly -> m1 wins every time; pointer changes do not block it.
REQ-037 Reset mid-transaction: rst during an m1 write ACCESS -> mem_write falls immediately, no m1_rvalid, next request starts from IDLE with m0 priority.
REQ-038 Strobe check, whole run: assert mem_read & mem_write is never 1, and mem_addr does not change while either strobe is high.
